uart_apb_sequencer: RTL and testbench
=====================================

Name: uart_apb_sequencer

Overview:
APB master that drives the UART APB bridge register map and shares it between two requesters: a TX byte source and an RX byte sink. On a configuration request it first writes the bridge enable and control registers. It then grants TX writes and RX reads round-robin, one APB transfer at a time. A PREADY timeout keeps a read of an empty RX path from hanging the bus.

Parameters:
TIMEOUT, 255, max ACCESS cycles waiting for PREADY before abort (>=2)
ENABLE_WORD, 32'h3, PWDATA written to address 0x00 (bit0 rx_enable, bit1 tx_enable)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: run configuration sequence
cfg_parity  in  2  parity_type written to control[1:0], sampled at cfg_start
cfg_baud  in  2  baud_rate written to control[3:2], sampled at cfg_start
tx_req  in  1  level; TX byte pending; held with tx_data until tx_ack
tx_data  in  8  byte to transmit
tx_ack  out  1  one-cycle pulse: TX write completed
rx_req  in  1  level; sink wants a byte; held until rx_valid
rx_data  out  8  received byte, valid with rx_valid, held until next rx_valid
rx_valid  out  1  one-cycle pulse: rx_data updated
configured  out  1  configuration sequence completed
busy  out  1  APB transfer in progress (SETUP or ACCESS)
err_timeout  out  1  one-cycle pulse: transfer aborted on timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  5  APB address
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (async, PRESETn=0): FSM=IDLE; all outputs 0; cfg_pending=0, last_grant=RX (TX wins first tie); timeout counter 0. Reset mid-transfer drops PSEL/PENABLE immediately; no ack/valid is issued.
- States: IDLE, SETUP, ACCESS, DONE. Op register selects EN, CTL, TX or RX.
- cfg_start in any state sets cfg_pending and latches parity/baud into cfg_word = {28'b0, baud, parity}. A second cfg_start before service overwrites cfg_word.
- IDLE grant priority:
  - cfg_pending -> op EN.
  - Else, if configured: tx_req and rx_req resolved round-robin against last_grant; single request granted directly.
  - Requests while configured=0 are not granted; they stay pending.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven per op:
  - EN: 0x00, write, ENABLE_WORD
  - CTL: 0x04, write, cfg_word
  - TX: 0x0C, write, {24'b0, tx_data}
  - RX: 0x0C, read, 0
- ACCESS: PSEL=1, PENABLE=1, address/data stable. Counter increments each cycle.
  - On PREADY=1: complete. For RX, capture PRDATA[7:0]. Go to DONE.
  - If counter reaches TIMEOUT with PREADY=0: abort to DONE with the error flag set.
- DONE (1 cycle): PSEL=0, PENABLE=0 (the bridge needs PENABLE low to clear PREADY). Registered pulses issued here:
  - TX complete: tx_ack.
  - RX complete: rx_valid with new rx_data.
  - EN complete: next op CTL.
  - CTL complete: configured<=1, cfg_pending<=0.
  - Abort: err_timeout. The request stays pending and is retried on a later grant; an aborted EN/CTL restarts at EN.
- DONE goes to IDLE, or directly to SETUP for the CTL step. Minimum one PSEL-low cycle between transfers.
- Latency with PREADY registered by the slave (first ACCESS cycle +1): grant cycle N (IDLE), SETUP N+1, ACCESS N+2..N+3, DONE/pulse N+4.
- last_grant updates only on TX/RX grant, not on config ops.
- busy=1 in SETUP and ACCESS only.
- cfg_start after configured=1 reruns the sequence; configured stays 1; TX/RX are blocked while cfg_pending=1.

Test Plan:
- Reset, cfg_start with parity=2'b01, baud=2'b10 -> write 0x00 PWDATA=0x3, then write 0x04 PWDATA=0x9; configured=1 after 2nd DONE; no PSEL between them for exactly 1 cycle.
- Configured, tx_req with tx_data=0xA5 -> SETUP PADDR=0x0C PWRITE=1 PWDATA=0xA5; PREADY high 1 cycle after ACCESS start -> tx_ack pulse 1 cycle, PSEL low that cycle.
- tx_req and rx_req asserted together and held; slave returns PRDATA=0x5C -> grant order TX, RX, TX, RX; rx_data=0x5C with rx_valid pulse.
- TIMEOUT=8, rx_req with PREADY never high -> exactly 8 ACCESS cycles, err_timeout pulse, no rx_valid, retry SETUP after 1 idle cycle.
- tx_req held before cfg_start -> no PSEL; after configured=1, TX transfer issues.
- PRESETn low during ACCESS of TX write -> PSEL/PENABLE 0 asynchronously, no tx_ack, configured=0; after release, tx_req is not granted until a new cfg_start.

Source files
------------

// File: rtl/uart_apb_sequencer.sv
// rtl/uart_apb_sequencer.sv - APB master sequencing bridge config, TX writes and RX reads
// Configuration (EN then CTL) has absolute priority; TX/RX share the bus round-robin.
module uart_apb_sequencer #(
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ENABLE_WORD = 32'h3
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cfg_start,
  input  logic [1:0]  cfg_parity,
  input  logic [1:0]  cfg_baud,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_ack,
  input  logic        rx_req,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        configured,
  output logic        busy,
  output logic        err_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [4:0]    ADDR_EN   = 5'h00;
  localparam logic [4:0]    ADDR_CTL  = 5'h04;
  localparam logic [4:0]    ADDR_DATA = 5'h0C;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OP_EN, OP_CTL, OP_TX, OP_RX} op_t;

  state_t        state;
  op_t           op;
  logic          cfg_pending;
  logic [31:0]   cfg_word;
  logic          last_rx;
  logic [CW-1:0] cnt;
  logic          grant_tx;
  logic          grant_rx;
  logic          unused_prdata;

  assign unused_prdata = ^PRDATA[31:8];

  // last_rx=1 means RX was served last, so TX wins the next tie.
  assign grant_tx = configured && !cfg_pending && tx_req && (!rx_req || last_rx);
  assign grant_rx = configured && !cfg_pending && rx_req && !grant_tx;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      op          <= OP_EN;
      cfg_pending <= 1'b0;
      cfg_word    <= '0;
      last_rx     <= 1'b1;
      cnt         <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      tx_ack      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      err_timeout <= 1'b0;
      configured  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tx_ack      <= 1'b0;
      rx_valid    <= 1'b0;
      err_timeout <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_pending) begin
            op     <= OP_EN;
            state  <= S_SETUP;
            PSEL   <= 1'b1;
            busy   <= 1'b1;
            PWRITE <= 1'b1;
            PADDR  <= ADDR_EN;
            PWDATA <= ENABLE_WORD;
          end else if (grant_tx) begin
            op      <= OP_TX;
            state   <= S_SETUP;
            PSEL    <= 1'b1;
            busy    <= 1'b1;
            PWRITE  <= 1'b1;
            PADDR   <= ADDR_DATA;
            PWDATA  <= {24'b0, tx_data};
            last_rx <= 1'b0;
          end else if (grant_rx) begin
            op      <= OP_RX;
            state   <= S_SETUP;
            PSEL    <= 1'b1;
            busy    <= 1'b1;
            PWRITE  <= 1'b0;
            PADDR   <= ADDR_DATA;
            PWDATA  <= '0;
            last_rx <= 1'b1;
          end
        end

        S_SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (PREADY || cnt == CNT_LAST) begin
            state   <= S_DONE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            if (!PREADY) begin
              err_timeout <= 1'b1;
            end else begin
              case (op)
                OP_TX:   tx_ack <= 1'b1;
                OP_RX: begin
                  rx_valid <= 1'b1;
                  rx_data  <= PRDATA[7:0];
                end
                OP_CTL: begin
                  configured  <= 1'b1;
                  cfg_pending <= 1'b0;
                end
                default: ;
              endcase
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DONE: begin
          // A successful EN chains straight into CTL; an aborted EN/CTL
          // falls back to IDLE where cfg_pending restarts at EN.
          if (op == OP_EN && !err_timeout) begin
            op     <= OP_CTL;
            state  <= S_SETUP;
            PSEL   <= 1'b1;
            busy   <= 1'b1;
            PWRITE <= 1'b1;
            PADDR  <= ADDR_CTL;
            PWDATA <= cfg_word;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Placed last so a fresh request outranks a same-cycle CTL completion.
      if (cfg_start) begin
        cfg_pending <= 1'b1;
        cfg_word    <= {28'b0, cfg_baud, cfg_parity};
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// tb/tb_uart_apb_sequencer.sv - self-checking bench for uart_apb_sequencer
// Behavioural APB slave plus a transfer-list reference model built from the arbitration rules.
module tb_uart_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cfg_start;
  logic [1:0]  cfg_parity;
  logic [1:0]  cfg_baud;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic        rx_req;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        configured;
  logic        busy;
  logic        err_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  always #5 PCLK = ~PCLK;

  uart_apb_sequencer #(.TIMEOUT(8), .ENABLE_WORD(32'h3)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_start(cfg_start), .cfg_parity(cfg_parity),
    .cfg_baud(cfg_baud), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_req(rx_req), .rx_data(rx_data), .rx_valid(rx_valid), .configured(configured),
    .busy(busy), .err_timeout(err_timeout), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observed activity
  logic [4:0]  s_addr[$];
  logic        s_wr[$];
  logic [31:0] s_data[$];
  int          gap_q[$];
  int          ev_acc[$];
  int          ev_lat[$];
  int          ev_kind[$];
  logic [7:0]  obs_rx[$];
  // Expected activity
  logic [4:0]  e_addr[$];
  logic        e_wr[$];
  logic [31:0] e_data[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  tx_bytes[$];
  logic        exp_last_rx;

  int cyc = 0, setup_cyc = 0, acc = 0, low_cnt = 0;

  initial forever begin
    @(negedge PCLK);
    cyc++;
    chk("busy_vs_psel", 32'(busy), 32'(PSEL));
    if (PSEL) begin
      if (!PENABLE) begin
        s_addr.push_back(PADDR);
        s_wr.push_back(PWRITE);
        s_data.push_back(PWDATA);
        gap_q.push_back(low_cnt);
        setup_cyc = cyc;
        acc = 0;
      end else begin
        acc++;
      end
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    if (tx_ack || rx_valid || err_timeout) begin
      chk("pulse_psel_low", 32'(PSEL), 32'd0);
      ev_acc.push_back(acc);
      ev_lat.push_back(cyc - setup_cyc);
      ev_kind.push_back(tx_ack ? 1 : (rx_valid ? 2 : 3));
      if (rx_valid) obs_rx.push_back(rx_data);
    end
  end

  // APB slave: PREADY registered, asserted after slave_wait extra ACCESS cycles
  logic        slave_hang;
  int          slave_wait;
  logic        rd_fixed_en;
  logic [31:0] rd_fixed;
  int          acc_s;

  initial begin
    PREADY = 1'b0;
    PRDATA = '0;
    acc_s  = 0;
    forever begin
      @(posedge PCLK);
      #1;
      if (PSEL && PENABLE) begin
        if (!PREADY && !slave_hang) begin
          if (acc_s >= slave_wait) begin
            PREADY = 1'b1;
            if (!PWRITE) begin
              PRDATA = rd_fixed_en ? rd_fixed : $urandom;
              exp_rx.push_back(PRDATA[7:0]);
            end
          end
          acc_s++;
        end
      end else begin
        PREADY = 1'b0;
        acc_s  = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic clear_logs();
    s_addr.delete(); s_wr.delete(); s_data.delete(); gap_q.delete();
    ev_acc.delete(); ev_lat.delete(); ev_kind.delete(); obs_rx.delete();
    e_addr.delete(); e_wr.delete(); e_data.delete(); exp_rx.delete();
  endtask

  task automatic exp_push(input logic [4:0] a, input logic w, input logic [31:0] d);
    e_addr.push_back(a);
    e_wr.push_back(w);
    e_data.push_back(d);
  endtask

  task automatic exp_cfg(input logic [1:0] par, input logic [1:0] baud);
    exp_push(5'h00, 1'b1, 32'h3);
    exp_push(5'h04, 1'b1, 32'(baud) * 4 + 32'(par));
  endtask

  // Both requesters held: alternate while both have work, starting opposite to the last grant.
  task automatic exp_traffic(input int ntx, input int nrx);
    int ti = 0;
    int ri = 0;
    while (ti < ntx || ri < nrx) begin
      if (ti < ntx && (ri >= nrx || exp_last_rx)) begin
        exp_push(5'h0C, 1'b1, 32'(tx_bytes[ti]));
        ti++;
        exp_last_rx = 1'b0;
      end else begin
        exp_push(5'h0C, 1'b0, 32'd0);
        ri++;
        exp_last_rx = 1'b1;
      end
    end
  endtask

  task automatic compare_transfers(input string tag);
    int n;
    chk($sformatf("%s.count", tag), s_addr.size(), e_addr.size());
    n = (s_addr.size() < e_addr.size()) ? s_addr.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 32'(s_addr[i]), 32'(e_addr[i]));
      chk($sformatf("%s.wr%0d", tag, i), 32'(s_wr[i]), 32'(e_wr[i]));
      chk($sformatf("%s.data%0d", tag, i), s_data[i], e_data[i]);
    end
  endtask

  task automatic compare_rx(input string tag);
    int n;
    chk($sformatf("%s.rxcount", tag), obs_rx.size(), exp_rx.size());
    n = (obs_rx.size() < exp_rx.size()) ? obs_rx.size() : exp_rx.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.rx%0d", tag, i), 32'(obs_rx[i]), 32'(exp_rx[i]));
  endtask

  task automatic run_traffic(input int ntx, input int nrx);
    fork
      begin
        for (int i = 0; i < ntx; i++) begin
          int k;
          k = 0;
          tx_data = tx_bytes[i];
          tx_req  = 1'b1;
          do begin tick(); k++; end while (!tx_ack && k < 300);
          chk("tx_ack_seen", 32'(tx_ack), 32'd1);
          if (i == ntx - 1) tx_req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < nrx; i++) begin
          int k;
          k = 0;
          rx_req = 1'b1;
          do begin tick(); k++; end while (!rx_valid && k < 300);
          chk("rx_valid_seen", 32'(rx_valid), 32'd1);
          if (i == nrx - 1) rx_req = 1'b0;
        end
      end
    join
    tick();
  endtask

  initial begin
    int k;
    int ntx, nrx;
    logic [1:0] par, baud;
    PRESETn = 1'b0; cfg_start = 1'b0; cfg_parity = '0; cfg_baud = '0;
    tx_req = 1'b0; tx_data = '0; rx_req = 1'b0;
    slave_hang = 1'b0; slave_wait = 1; rd_fixed_en = 1'b0; rd_fixed = '0;
    exp_last_rx = 1'b1;
    repeat (3) tick();

    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_pulses", {29'b0, tx_ack, rx_valid, err_timeout}, 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    PRESETn = 1'b1;

    // TX pending before configuration must wait for it
    clear_logs();
    tx_bytes = '{8'hA5};
    tx_data = 8'hA5;
    tx_req  = 1'b1;
    repeat (20) tick();
    chk("precfg_no_psel", s_addr.size(), 0);
    chk("precfg_configured", 32'(configured), 32'd0);
    cfg_parity = 2'b01; cfg_baud = 2'b10; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_parity = 2'b00; cfg_baud = 2'b00;
    exp_cfg(2'b01, 2'b10);
    exp_traffic(1, 0);
    run_traffic(1, 0);
    chk("cfg_configured", 32'(configured), 32'd1);
    chk("tx_ack_one_cycle", 32'(tx_ack), 32'd0);
    compare_transfers("cfg_tx");
    chk("gap_en_ctl", qget(gap_q, 1), 1);
    chk("gap_ctl_tx", qget(gap_q, 2), 2);
    chk("tx_latency", qget(ev_lat, 0), 3);
    chk("tx_access_cycles", qget(ev_acc, 0), 2);
    chk("tx_events", ev_kind.size(), 1);

    // RX read against a slave that never answers: abort, then retry
    clear_logs();
    slave_hang = 1'b1; rd_fixed_en = 1'b1; rd_fixed = 32'h0000_1277;
    rx_req = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!err_timeout && k < 100);
    chk("to_err_seen", 32'(err_timeout), 32'd1);
    chk("to_access_cycles", qget(ev_acc, 0), 8);
    chk("to_no_rx_valid", obs_rx.size(), 0);
    k = 0;
    while (s_addr.size() < 2 && k < 20) begin tick(); k++; end
    chk("to_retry_gap", qget(gap_q, 1), 2);
    slave_hang = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!rx_valid && k < 100);
    chk("to_rx_valid_seen", 32'(rx_valid), 32'd1);
    chk("to_rx_data", 32'(rx_data), 32'h77);
    rx_req = 1'b0;
    tick();
    exp_push(5'h0C, 1'b0, 32'd0);
    exp_push(5'h0C, 1'b0, 32'd0);
    exp_last_rx = 1'b1;
    compare_transfers("timeout");
    chk("to_rx_count", obs_rx.size(), 1);

    // Both requesters held, fixed read data: TX, RX, TX, RX
    clear_logs();
    rd_fixed = 32'hFFFF_FF5C;
    tx_bytes = '{8'h3C, 8'hC3};
    exp_traffic(2, 2);
    run_traffic(2, 2);
    compare_transfers("rr");
    chk("rr_rx_count", obs_rx.size(), 2);
    for (int i = 0; i < obs_rx.size(); i++) chk("rr_rx_data", 32'(obs_rx[i]), 32'h5C);

    // Randomized rounds, one with a reconfiguration while configured
    rd_fixed_en = 1'b0;
    for (int r = 0; r < 5; r++) begin
      clear_logs();
      slave_wait = $urandom_range(0, 3);
      ntx = $urandom_range(1, 5);
      nrx = $urandom_range(1, 5);
      tx_bytes.delete();
      for (int i = 0; i < ntx; i++) tx_bytes.push_back(8'($urandom));
      if (r == 2) begin
        par = 2'($urandom); baud = 2'($urandom);
        cfg_parity = par; cfg_baud = baud; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        exp_cfg(par, baud);
      end
      exp_traffic(ntx, nrx);
      run_traffic(ntx, nrx);
      chk($sformatf("rnd%0d_configured", r), 32'(configured), 32'd1);
      compare_transfers($sformatf("rnd%0d", r));
      compare_rx($sformatf("rnd%0d", r));
    end

    // Reset in the middle of a TX write
    clear_logs();
    slave_hang = 1'b1; slave_wait = 1;
    tx_data = 8'h42; tx_req = 1'b1;
    k = 0;
    while (!(PSEL && PENABLE) && k < 20) begin tick(); k++; end
    chk("rstmid_in_access", 32'(PSEL && PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("rstmid_psel", 32'(PSEL), 32'd0);
    chk("rstmid_penable", 32'(PENABLE), 32'd0);
    chk("rstmid_configured", 32'(configured), 32'd0);
    repeat (2) tick();
    PRESETn = 1'b1;
    slave_hang = 1'b0;
    exp_last_rx = 1'b1;
    exp_push(5'h0C, 1'b1, 32'h42);
    repeat (20) tick();
    chk("rstmid_no_new_setup", s_addr.size(), 1);
    chk("rstmid_no_ack", ev_kind.size(), 0);
    cfg_parity = 2'b11; cfg_baud = 2'b00; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    exp_cfg(2'b11, 2'b00);
    tx_bytes = '{8'h42};
    exp_traffic(1, 0);
    run_traffic(1, 0);
    compare_transfers("rstmid");
    chk("rstmid_ack_count", ev_kind.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
